cr_tlvp2_usr_arb: RTL
=====================

// Module: cr_tlvp2_usr_arb
// PURPOSE
//  Round-robin arbiter that merges NREQ user-TLV sources into the single usr_ob stream consumed by the TLVP2 reassembly core.
//  Grants at whole-TLV granularity, sot through eot. With FRAME_LOCK=1 it holds a source until that source's tlast word.
//  Drains malformed heads (first word without sot) and keeps a wrapping count of forwarded TLVs.
// PARAMETERS
//  NREQ        4   number of requesters, 2..8
//  PW          83  payload width per word (tdata/tuser/tid/tstrb/ordern/typen/insert packed); passed through opaquely
//  FRAME_LOCK  1   1: keep the grant on the same requester until a word with tlast; 0: re-arbitrate after every eot
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset: asynchronous, active-low
//  req_empty    in   NREQ     per-requester show-ahead FIFO empty
//  req_data     in   NREQ*PW  head-word payload; requester i occupies [i*PW +: PW]
//  req_sot      in   NREQ     head word is start-of-TLV
//  req_eot      in   NREQ     head word is end-of-TLV
//  req_tlast    in   NREQ     head word is last of frame
//  req_rd       out  NREQ     pop the head word (one-hot or zero)
//  usr_afull    in   1        usr_ob FIFO almost full
//  usr_wen      out  1        usr_ob write strobe
//  usr_wdata    out  PW       written payload
//  usr_sot      out  1        written sot
//  usr_eot      out  1        written eot
//  usr_tlast    out  1        written tlast
//  err_drop     out  1        1-cycle pulse: a head word without sot was discarded
//  err_sot      out  1        1-cycle pulse: sot seen on a non-first word of a granted TLV (word is still forwarded)
//  tlv_cnt      out  16       count of eot words written; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr_ptr=0; gnt=0; lock=0; tlv_cnt=0. Assertion mid-TLV discards the partial TLV; no recovery.
//  Eligibility (IDLE): ~req_empty[i] & req_sot[i], and if lock=1 then also i==gnt.
//  IDLE:
//   - If any requester is eligible, pick the first one at or after rr_ptr (cyclic search), register gnt, go to BUSY. No pop in this cycle (one bubble per TLV).
//   - Drain: the lowest-index requester with ~empty & ~sot that is not the one granted this cycle gets req_rd=1 and err_drop=1.
//   - Drain ignores usr_afull and lock. Max one drain per cycle.
//  BUSY:
//   - req_rd[gnt] = ~req_empty[gnt] & ~usr_afull; all other req_rd bits are 0.
//   - On a pop: registered write next cycle (latency 1): usr_wen=1, and usr_wdata/sot/eot/tlast = the popped head.
//   - No pop: usr_wen=0 and data outputs hold their last value.
//   - Popped word with eot:
//     - go to IDLE; rr_ptr <= (gnt+1) mod NREQ; tlv_cnt increments together with that word's usr_wen;
//     - lock <= FRAME_LOCK & ~tlast; rr_ptr is still advanced, but only gnt can win while lock=1.
//   - err_sot pulses, aligned with usr_wen, when a popped word has sot and is not the first word since the grant.
//  Simultaneous events:
//   - Pop with eot plus another requester eligible: that requester is granted in the following IDLE cycle, not the same cycle.
//   - usr_afull rising mid-TLV: stall with gnt held; no word lost or duplicated.
//   - Single eligible requester: back-to-back TLVs run at 1 bubble per TLV.
//  Width: rr_ptr and gnt are $clog2(NREQ) bits; the cyclic search wraps modulo NREQ.
// TESTING
//  1. NREQ=4, requesters 0 and 2 each hold one 3-word TLV (no tlast), FRAME_LOCK=0.
//     -> Grant order 0 then 2. usr_wen pattern 0,1,1,1,0,1,1,1. tlv_cnt=2. rr_ptr=3.
//  2. FRAME_LOCK=1. req1 has TLV A (eot, ~tlast) then TLV B (eot, tlast); req0 is ready throughout.
//     -> Sequence A, B from req1, then req0. lock clears after B.
//  3. usr_afull held high for 5 cycles mid-TLV.
//     -> req_rd=0 and usr_wen=0 for those cycles; the TLV then resumes intact with word order preserved.
//  4. req3 head is a non-sot word while in IDLE and req1 is eligible.
//     -> req3 popped with err_drop=1 in the same cycle that req1 is granted; nothing forwarded from req3.
//  5. Word 2 of a granted TLV carries sot.
//     -> err_sot=1 in the cycle the word is written; the word is still forwarded.
//  6. tlv_cnt preset by traffic to 0xFFFF, then one more TLV; also reset asserted mid-TLV.
//     -> tlv_cnt=0x0000. On reset, all outputs go to 0 asynchronously and state returns to IDLE.

Source files
------------

// File: rtl/cr_tlvp2_usr_arb_if.sv
// Bus bundle between the user-TLV requester FIFOs, the usr_ob write port and the arbiter.
// The master side drives FIFO heads and afull, and the slave side (the arbiter) pops and writes.
interface cr_tlvp2_usr_arb_if #(
  parameter int NREQ = 4,
  parameter int PW   = 83
);
  logic [NREQ-1:0]    req_empty;
  logic [NREQ*PW-1:0] req_data;
  logic [NREQ-1:0]    req_sot;
  logic [NREQ-1:0]    req_eot;
  logic [NREQ-1:0]    req_tlast;
  logic [NREQ-1:0]    req_rd;
  logic               usr_afull;
  logic               usr_wen;
  logic [PW-1:0]      usr_wdata;
  logic               usr_sot;
  logic               usr_eot;
  logic               usr_tlast;

  modport master (
    output req_empty, req_data, req_sot, req_eot, req_tlast, usr_afull,
    input  req_rd, usr_wen, usr_wdata, usr_sot, usr_eot, usr_tlast
  );

  modport slave (
    input  req_empty, req_data, req_sot, req_eot, req_tlast, usr_afull,
    output req_rd, usr_wen, usr_wdata, usr_sot, usr_eot, usr_tlast
  );
endinterface

// File: rtl/cr_tlvp2_usr_arb.sv
// Round-robin merge of NREQ user-TLV sources into the usr_ob stream, granting whole TLVs
// (optionally whole frames), draining headless words and counting forwarded TLVs.
module cr_tlvp2_usr_arb #(
  parameter int NREQ       = 4,
  parameter int PW         = 83,
  parameter int FRAME_LOCK = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cr_tlvp2_usr_arb_if.slave    io_bus,
  output logic                 o_err_drop,
  output logic                 o_err_sot,
  output logic [15:0]          o_tlv_cnt
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_gnt;
  logic            r_lock;
  logic            r_first;
  logic            r_wen;
  logic [PW-1:0]   r_wdata;
  logic            r_sot;
  logic            r_eot;
  logic            r_tlast;
  logic            r_err_sot;
  logic [15:0]     r_tlv_cnt;

  logic [NREQ-1:0] w_elig;
  logic [GW:0]     w_idx;
  logic [GW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [NREQ-1:0] w_drain_oh;
  logic [NREQ-1:0] w_rd;
  logic            w_err_drop;
  logic            w_pop;
  logic [PW-1:0]   w_g_data;
  logic            w_g_empty;
  logic            w_g_sot;
  logic            w_g_eot;
  logic            w_g_tlast;
  logic [GW-1:0]   w_ptr_nxt;

  always_comb begin
    w_g_data  = '0;
    w_g_empty = 1'b1;
    w_g_sot   = 1'b0;
    w_g_eot   = 1'b0;
    w_g_tlast = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt == GW'(i)) begin
        w_g_data  = io_bus.req_data[i*PW +: PW];
        w_g_empty = io_bus.req_empty[i];
        w_g_sot   = io_bus.req_sot[i];
        w_g_eot   = io_bus.req_eot[i];
        w_g_tlast = io_bus.req_tlast[i];
      end
    end
  end

  // While a frame is locked only the locked requester may start a new TLV.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++)
      w_elig[i] = ~io_bus.req_empty[i] & io_bus.req_sot[i] & (~r_lock | (r_gnt == GW'(i)));
  end

  // Descending scan so the candidate closest to rr_ptr is the one that sticks.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(NREQ))
        w_idx = w_idx - (GW+1)'(NREQ);
      if (w_elig[w_idx[GW-1:0]]) begin
        w_pick     = w_idx[GW-1:0];
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_drain_oh = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (~io_bus.req_empty[i] & ~io_bus.req_sot[i] & ~(w_pick_vld & (w_pick == GW'(i))))
        w_drain_oh = NREQ'(1) << i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = BUSY;
      BUSY:    if (w_pop & w_g_eot) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rd       = '0;
    w_err_drop = 1'b0;
    if (rst_n) begin
      if (r_state == IDLE) begin
        w_rd       = w_drain_oh;
        w_err_drop = |w_drain_oh;
      end else if (~w_g_empty & ~io_bus.usr_afull) begin
        w_rd = NREQ'(1) << r_gnt;
      end
    end
  end

  assign w_pop     = (r_state == BUSY) & (|w_rd);
  assign w_ptr_nxt = (r_gnt == GW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

  // Output word, grant bookkeeping and TLV counter all move on the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_lock    <= 1'b0;
      r_first   <= 1'b0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_sot     <= 1'b0;
      r_eot     <= 1'b0;
      r_tlast   <= 1'b0;
      r_err_sot <= 1'b0;
      r_tlv_cnt <= '0;
    end else begin
      r_wen     <= w_pop;
      r_err_sot <= 1'b0;
      if ((r_state == IDLE) && w_pick_vld) begin
        r_gnt   <= w_pick;
        r_first <= 1'b1;
      end
      if (w_pop) begin
        r_wdata   <= w_g_data;
        r_sot     <= w_g_sot;
        r_eot     <= w_g_eot;
        r_tlast   <= w_g_tlast;
        r_err_sot <= w_g_sot & ~r_first;
        r_first   <= 1'b0;
        if (w_g_eot) begin
          r_rr_ptr  <= w_ptr_nxt;
          r_lock    <= (FRAME_LOCK != 0) & ~w_g_tlast;
          r_tlv_cnt <= r_tlv_cnt + 16'd1;
        end
      end
    end
  end

  assign io_bus.req_rd    = w_rd;
  assign io_bus.usr_wen   = r_wen;
  assign io_bus.usr_wdata = r_wdata;
  assign io_bus.usr_sot   = r_sot;
  assign io_bus.usr_eot   = r_eot;
  assign io_bus.usr_tlast = r_tlast;
  assign o_err_drop       = w_err_drop;
  assign o_err_sot        = r_err_sot;
  assign o_tlv_cnt        = r_tlv_cnt;
endmodule
